// File: rtl/ped_crossing_ctrl_if.sv
// Pedestrian crossing controller signal bundle.
// master drives the lamp/tick/button inputs; slave is the controller.
interface ped_crossing_ctrl_if;
  logic       tick;
  logic       red;
  logic       yellow;
  logic       green;
  logic       btn;
  logic       walk;
  logic       dont_walk;
  logic       ped_wait;
  logic [5:0] ped_count;
  logic       fault;

  modport master (
    output tick, red, yellow, green, btn,
    input  walk, dont_walk, ped_wait, ped_count, fault
  );

  modport slave (
    input  tick, red, yellow, green, btn,
    output walk, dont_walk, ped_wait, ped_count, fault
  );
endinterface

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian WALK / flashing / DON'T WALK stage behind the vehicle lights.
// Define PED_AUTO_WALK_EN to grant WALK on every red start without a request.
module ped_crossing_ctrl #(
  parameter int WALK_SEC        = 10,
  parameter int FLASH_SEC       = 5,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic          clk,
  input logic          reset,
  ped_crossing_ctrl_if.slave io
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [5:0] WALK_CNT  = 6'(WALK_SEC);
  localparam logic [5:0] FLASH_CNT = 6'(FLASH_SEC);

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    WALK  = 2'd1,
    FLASH = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [5:0] count, count_n;
  logic       flash_on, flash_n;
  logic       req, req_n;
  logic       sync1, sync2, level;
  logic [DW-1:0] db_cnt;
  logic       red_d;
  logic       lamp_bad, red_rise, deb_rise;
  logic       grant, auto_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      level  <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= io.btn;
      sync2 <= sync1;
      // any return to the current level restarts the stability count
      if (sync2 != level) begin
        if (db_cnt == DB_LAST) begin
          level  <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign deb_rise = sync2 & ~level & (db_cnt == DB_LAST);
  assign lamp_bad = (2'(io.red) + 2'(io.yellow) + 2'(io.green)) != 2'd1;
  assign red_rise = io.red & ~red_d;

`ifdef PED_AUTO_WALK_EN
  assign auto_ok = 1'b1;
`else
  assign auto_ok = req;
`endif

  always_comb begin
    state_n = state;
    count_n = count;
    flash_n = flash_on;
    req_n   = req;
    grant   = 1'b0;
    unique case (state)
      STOP: begin
        if (red_rise && !lamp_bad && auto_ok) begin
          grant   = 1'b1;
          state_n = WALK;
          count_n = WALK_CNT;
        end
      end
      WALK: begin
        if (!io.red || lamp_bad) begin
          state_n = STOP;
          count_n = 6'd0;
          flash_n = 1'b0;
        end else if (io.tick) begin
          if (count == 6'd1) begin
            state_n = FLASH;
            count_n = FLASH_CNT;
            flash_n = 1'b1;
          end else begin
            count_n = count - 6'd1;
          end
        end
      end
      FLASH: begin
        if (!io.red || lamp_bad) begin
          state_n = STOP;
          count_n = 6'd0;
          flash_n = 1'b0;
        end else if (io.tick) begin
          flash_n = ~flash_on;
          if (count == 6'd1) begin
            state_n = STOP;
            count_n = 6'd0;
          end else begin
            count_n = count - 6'd1;
          end
        end
      end
      default: begin
        state_n = STOP;
        count_n = 6'd0;
        flash_n = 1'b0;
      end
    endcase
    // a grant swallows any press landing in the same cycle
    if (grant) begin
      req_n = 1'b0;
    end else if (deb_rise && state != WALK) begin
      req_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= STOP;
      count        <= 6'd0;
      flash_on     <= 1'b0;
      req          <= 1'b0;
      red_d        <= 1'b0;
      io.walk      <= 1'b0;
      io.dont_walk <= 1'b1;
      io.ped_count <= 6'd0;
      io.fault     <= 1'b0;
    end else begin
      state        <= state_n;
      count        <= count_n;
      flash_on     <= flash_n;
      req          <= req_n;
      red_d        <= io.red;
      io.walk      <= (state == WALK);
      io.dont_walk <= (state == STOP) | ((state == FLASH) & flash_on);
      io.ped_count <= count;
      io.fault     <= lamp_bad;
    end
  end

  assign io.ped_wait = req;

endmodule
